pipe_skid_reg: RTL and testbench

//  Elastic pipeline stage register for the RISC-V core: the consumer-facing end of an

---
 rtl/riscv_pipe_pkg.sv | 12 +
 rtl/pipe_skid_reg.sv | 81 ++++++++
 tb/tb_pipe_skid_reg.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/riscv_pipe_pkg.sv
// rtl/riscv_pipe_pkg.sv - shared types and constants for the pipeline stage registers
package riscv_pipe_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_BUSY  = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - two-entry elastic stage register with registered upstream ready
module pipe_skid_reg
    import riscv_pipe_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    skid_state_t      state_q, state_n;
    logic [WIDTH-1:0] main_q, main_n;
    logic [WIDTH-1:0] skid_q, skid_n;
    logic             in_ready_q;
    logic             in_fire, out_fire;

    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = (state_q != SKID_EMPTY) & out_ready;
    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != SKID_EMPTY);
    assign out_data  = main_q;

    always_comb begin
        state_n = state_q;
        main_n  = main_q;
        skid_n  = skid_q;
        if (flush) begin
            // Squash wins over both handshakes: nothing enters, nothing counts as delivered.
            state_n = SKID_EMPTY;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (in_fire) begin
                        main_n  = in_data;
                        state_n = SKID_BUSY;
                    end
                end
                SKID_BUSY: begin
                    if (in_fire && out_fire) begin
                        main_n = in_data;
                    end else if (in_fire) begin
                        skid_n  = in_data;
                        state_n = SKID_FULL;
                    end else if (out_fire) begin
                        state_n = SKID_EMPTY;
                    end
                end
                SKID_FULL: begin
                    if (out_fire) begin
                        main_n  = skid_q;
                        state_n = SKID_BUSY;
                    end
                end
                default: state_n = SKID_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= SKID_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_n;
            main_q     <= main_n;
            skid_q     <= skid_n;
            // Ready comes straight from a flop so upstream never sees a combinational path.
            in_ready_q <= (state_n != SKID_FULL);
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - self-checking bench for pipe_skid_reg against a queue model
module tb_pipe_skid_reg;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, flush, in_valid, out_ready;
    logic [W-1:0] in_data;
    logic         in_ready, out_valid;
    logic [W-1:0] out_data;

    int checks = 0;
    int passes = 0;

    logic [W-1:0] mq[$];
    logic [W-1:0] got[$];
    logic         stalled;
    logic [W-1:0] stall_data;

    pipe_skid_reg #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference: a FIFO of capacity two; flush empties it, reset empties it immediately.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
        end else if (flush) begin
            mq.delete();
        end else begin
            bit ofire, ifire;
            ofire = (mq.size() > 0) && out_ready;
            ifire = in_valid && (mq.size() < 2);
            if (ofire) void'(mq.pop_front());
            if (ifire) mq.push_back(in_data);
        end
    end

    // Observe DUT deliveries and stall conditions using pre-edge values.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            stalled <= 1'b0;
        end else begin
            if (out_valid && out_ready && !flush) got.push_back(out_data);
            stalled    <= out_valid && !out_ready && !flush;
            stall_data <= out_data;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("in_ready", in_ready, (mq.size() < 2) ? 1 : 0);
            chk("out_valid", out_valid, (mq.size() > 0) ? 1 : 0);
            if (mq.size() > 0) chk("out_data", out_data, mq[0]);
            if (stalled) begin
                chk("stable_valid", out_valid, 1);
                chk("stable_data", out_data, stall_data);
            end
        end
    end

    task automatic cyc;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic ordy, input logic fl);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    initial begin
        int hits;
        reset = 1'b1;
        drive(0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        #1 reset = 1'b0;

        // Streaming at full rate.
        drive(1, 32'h11, 1, 0); cyc;
        chk("s1_data", out_data, 32'h11); chk("s1_valid", out_valid, 1);
        drive(1, 32'h22, 1, 0); cyc;
        chk("s2_data", out_data, 32'h22); chk("s2_ready", in_ready, 1);
        drive(1, 32'h33, 1, 0); cyc;
        chk("s3_data", out_data, 32'h33); chk("s3_ready", in_ready, 1);
        drive(0, 0, 1, 0); cyc;
        chk("s_drain", out_valid, 0);

        // Backpressure into FULL, then release.
        drive(1, 32'hA1, 0, 0); cyc;
        chk("b1_data", out_data, 32'hA1);
        drive(1, 32'hA2, 0, 0); cyc;
        chk("b2_ready", in_ready, 0); chk("b2_data", out_data, 32'hA1);
        drive(1, 32'hA3, 0, 0); cyc;
        chk("b3_hold", out_data, 32'hA1); chk("b3_ready", in_ready, 0);
        drive(1, 32'hA3, 1, 0); cyc;
        chk("b4_data", out_data, 32'hA2); chk("b4_ready", in_ready, 1);
        drive(1, 32'hA3, 1, 0); cyc;
        chk("b5_data", out_data, 32'hA3);
        drive(0, 0, 1, 0); cyc;
        chk("b_drain", out_valid, 0);

        // Simultaneous in/out while BUSY.
        drive(1, 32'h05, 0, 0); cyc;
        drive(1, 32'h06, 1, 0); cyc;
        chk("sim_data", out_data, 32'h06); chk("sim_ready", in_ready, 1);
        drive(0, 0, 1, 0); cyc;

        // Flush beats a concurrent push and pop.
        drive(1, 32'hB1, 0, 0); cyc;
        drive(1, 32'hB2, 0, 0); cyc;
        chk("f_full", in_ready, 0);
        drive(1, 32'hB3, 1, 1); cyc;
        chk("f_valid", out_valid, 0); chk("f_ready", in_ready, 1);
        drive(0, 0, 1, 0); repeat (3) cyc;
        hits = 0;
        foreach (got[i]) if (got[i] inside {32'hB1, 32'hB2, 32'hB3}) hits++;
        chk("f_none_seen", hits, 0);

        // Asynchronous reset while FULL, checked before any further edge.
        drive(1, 32'hC1, 0, 0); cyc;
        drive(1, 32'hC2, 0, 0); cyc;
        drive(0, 0, 0, 0);
        #1 reset = 1'b1;
        #1;
        chk("ar_in_ready", in_ready, 1);
        chk("ar_out_valid", out_valid, 0);
        chk("ar_out_data", out_data, 0);
        @(negedge clk); #1 reset = 1'b0;

        // Random traffic with occasional flush.
        for (int i = 0; i < 10000; i++) begin
            drive($urandom_range(0, 1), $urandom, $urandom_range(0, 1),
                  ($urandom_range(0, 63) == 0));
            cyc;
        end
        drive(0, 0, 1, 0); repeat (4) cyc;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
